// File: rtl/if_stage_pipe.sv
// Purpose : LEGv8 instruction-fetch stage with IF/ID pipeline register.
// Latency : a fetch that completes at a rising edge appears in IF/ID at that same edge.
// Backpr. : decode stall holds IF/ID; a word fetched during a stall parks in a one-entry skid buffer.
//
// Ports:
//   CLK, RESET                    - clock (rising edge), asynchronous active-high reset
//   stall                         - decode cannot accept; IF/ID holds its contents
//   branch_taken, branch_target   - redirect from EX/MEM; flushes the fetch stage
//   imem_req, imem_addr           - fetch request and address (the current PC)
//   imem_ready, imem_rdata        - memory response strobe and instruction word
//   pc_out, instruction_out       - IF/ID contents presented to decode
//   valid_out                     - IF/ID holds a real instruction (0 = bubble)
module if_stage_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    // FETCH : a request is outstanding at pc.
    // HOLD  : a fetched word waits in the skid buffer for decode to free up; no request.
    // DRAIN : a redirect arrived while a fetch was in flight; the memory must finish
    //         that access before the address may change, and its data is thrown away.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic [31:0] saved_target;

    // Wraps modulo 2^32 by construction.
    assign pc_seq = pc + PC_INC;

    // The address must not move while a request is pending, so it is simply the PC;
    // the PC itself only changes when a fetch completes or while no request is out.
    assign imem_addr = pc;
    assign imem_req  = !RESET && ((state == FETCH) || (state == DRAIN));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            skid_pc         <= 32'h0;
            skid_instr      <= 32'h0;
            saved_target    <= 32'h0;
            pc_out          <= 32'h0;
            instruction_out <= 32'h0;
            valid_out       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        // Redirect wins over stall: whatever decode holds is wrong-path.
                        valid_out <= 1'b0;
                        if (imem_ready) begin
                            pc <= branch_target;
                        end else begin
                            saved_target <= branch_target;
                            state        <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        pc <= pc_seq;
                        if (!stall) begin
                            pc_out          <= pc;
                            instruction_out <= imem_rdata;
                            valid_out       <= 1'b1;
                        end else begin
                            skid_pc    <= pc;
                            skid_instr <= imem_rdata;
                            state      <= HOLD;
                        end
                    end else if (!stall) begin
                        valid_out <= 1'b0;
                    end
                end

                HOLD: begin
                    if (branch_taken) begin
                        // Skid contents are wrong-path; simply never forwarded.
                        valid_out <= 1'b0;
                        pc        <= branch_target;
                        state     <= FETCH;
                    end else if (!stall) begin
                        pc_out          <= skid_pc;
                        instruction_out <= skid_instr;
                        valid_out       <= 1'b1;
                        state           <= FETCH;
                    end
                end

                DRAIN: begin
                    if (branch_taken) begin
                        saved_target <= branch_target;
                    end
                    if (imem_ready) begin
                        // A redirect in the completing cycle is the newest one.
                        pc    <= branch_taken ? branch_target : saved_target;
                        state <= FETCH;
                    end
                    if (!stall) begin
                        valid_out <= 1'b0;
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_pipe.sv
// Purpose : self-checking bench for if_stage_pipe (directed scenarios, then random traffic).
// Latency : expected IF/ID contents are derived from a fetch-queue reference model.
// Backpr. : memory wait states, decode stalls, redirects and reset pulses are all driven randomly.
module tb_if_stage_pipe;

    logic        CLK;
    logic        RESET;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction memory contents: a scrambled function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    if_stage_pipe dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Fetched-but-undelivered words sit in exp_q in program
    // order. A redirect empties the queue; a redirect that lands while a fetch
    // is outstanding marks that fetch abandoned, and the next address becomes
    // the newest redirect target once the memory finishes. A fetch is
    // outstanding exactly when nothing is waiting to be delivered.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] next_addr = 32'h0;
    logic [31:0] saved     = 32'h0;
    bit          abandoned = 1'b0;

    always @(posedge CLK) begin
        if (RESET) begin
            exp_q.delete();
            next_addr = 32'h0;
            saved     = 32'h0;
            abandoned = 1'b0;
        end else begin
            bit req_active;
            bit done;
            req_active = (exp_q.size() == 0);
            done       = req_active && imem_ready;
            if (branch_taken) begin
                exp_q.delete();
                if (!req_active || done) begin
                    next_addr = branch_target;
                    abandoned = 1'b0;
                end else begin
                    abandoned = 1'b1;
                    saved     = branch_target;
                end
            end else if (done) begin
                if (abandoned) begin
                    next_addr = saved;
                    abandoned = 1'b0;
                end else begin
                    exp_q.push_back('{pc: next_addr, ins: mem_word(next_addr)});
                    next_addr = next_addr + 32'd4;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: after each edge, work out what IF/ID must hold and compare.
    // ------------------------------------------------------------------
    logic        exp_v   = 1'b0;
    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] exp_ins = 32'h0;

    always @(posedge CLK) begin
        #1;
        if (RESET) begin
            exp_v   = 1'b0;
            exp_pc  = 32'h0;
            exp_ins = 32'h0;
            chk("reset_valid", 32'(valid_out), 32'd0);
            chk("reset_pc_out", pc_out, 32'h0);
            chk("reset_instr", instruction_out, 32'h0);
            chk("reset_req", 32'(imem_req), 32'd0);
        end else begin
            if (branch_taken) begin
                exp_v = 1'b0;
            end else if (!stall) begin
                if (exp_q.size() > 0) begin
                    ent_t e;
                    e       = exp_q.pop_front();
                    exp_v   = 1'b1;
                    exp_pc  = e.pc;
                    exp_ins = e.ins;
                end else begin
                    exp_v = 1'b0;
                end
            end
            chk("valid_out", 32'(valid_out), 32'(exp_v));
            if (exp_v) begin
                chk("pc_out", pc_out, exp_pc);
                chk("instruction_out", instruction_out, exp_ins);
            end
            chk("imem_req", 32'(imem_req), 32'(exp_q.size() == 0));
            if (exp_q.size() == 0) begin
                chk("imem_addr", imem_addr, next_addr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change on the falling edge only.
    // ------------------------------------------------------------------
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
        imem_ready    = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        @(negedge CLK);
    endtask

    // Asynchronous reset pulse starting between edges; called on a falling edge.
    task automatic pulse_reset();
        #2;
        RESET = 1'b1;
        #1;
        chk("async_reset_valid", 32'(valid_out), 32'd0);
        chk("async_reset_pc_out", pc_out, 32'h0);
        chk("async_reset_instr", instruction_out, 32'h0);
        chk("async_reset_req", 32'(imem_req), 32'd0);
        chk("async_reset_addr", imem_addr, 32'h0);
        // Any memory response now in flight must be ignored.
        imem_ready   = 1'b1;
        branch_taken = 1'b0;
        stall        = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_addr_is_reset_pc", imem_addr, 32'h0);
        RESET = 1'b0;

        // Zero-wait streaming: 0, 4, 8, C from the first edge.
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        // Stall while a fetch completes, held for three cycles, then release.
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        // Redirect coinciding with a completing fetch.
        cyc(1'b1, 1'b0, 1'b1, 32'h100);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        // Three wait cycles with two redirects in flight; newest target wins.
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h200);
        cyc(1'b0, 1'b0, 1'b1, 32'h300);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        // Redirect together with stall while the skid buffer is full.
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h400);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        // PC wrap-around.
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        // Reset in the middle of a drain; fetch restarts at the reset PC.
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h500);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        pulse_reset();
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic        r;
            logic        s;
            logic        b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 60);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 8);
            t = $urandom;
            t[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000C);
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                cyc(r, s, b, t);
            end
        end

        repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
